dcache_port_b: RTL and testbench
================================

// Module: dcache_port_b
// PURPOSE
// - Data-side responder for the MEM stage's port-B handshake: read_b/write/wmask/address_b/wdata in, resp_b/rdata_b out.
// - Blocking, direct-mapped cache with 16-byte lines. Write-through, no-write-allocate.
// - Read misses refill a line from physical memory in a 4-beat burst. Sits between the MEM stage and the pmem arbiter.
// PARAMETERS
// - SETS    16  number of lines; power of 2, >=2; index = address[3+$clog2(SETS):4]
// - BEATS   4   words per line, fixed; present for readability only
// PORTS
// - clk           in   1   rising-edge clock
// - rst_n         in   1   synchronous reset, active low
// - read_b        in   1   load request; held with address until resp_b
// - write         in   1   store request; held with address/wdata/wmask until resp_b
// - wmask         in   4   byte enables for stores
// - address_b     in   32  byte address; [1:0] ignored for word select
// - wdata         in   32  store data, byte lanes per wmask
// - resp_b        out  1   one-cycle completion pulse
// - rdata_b       out  32  load data, valid with resp_b; 0 otherwise
// - pmem_read     out  1   burst read request; held until 4th pmem_resp
// - pmem_write    out  1   single-word write request; held until pmem_resp
// - pmem_address  out  32  line-aligned for reads; word-aligned for writes
// - pmem_wdata    out  32  = wdata during a write
// - pmem_wmask    out  4   = wmask during a write
// - pmem_rdata    in   32  burst beat data; words 0..3 in order
// - pmem_resp     in   1   beat/write acknowledge
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state IDLE, all valid bits 0, beat counter 0.
//   All outputs 0 from the following cycle. Tag/data arrays are not cleared.
// - FSM states:
//   - IDLE: read hit -> resp_b=1 combinationally, same cycle (0-cycle latency), rdata_b = array word. Stay IDLE.
//     Read miss -> FILL. write -> WRITE. read_b and write both high: write wins.
//   - FILL: pmem_read=1, pmem_address={tag,index,4'b0}. Each pmem_resp stores pmem_rdata into word[beat], beat++.
//     On beat==3 with pmem_resp: write tag, set valid -> DONE. Counter wraps to 0.
//   - WRITE: pmem_write=1, address={address_b[31:2],2'b0}. On pmem_resp: if tag hit, merge wdata into the line per wmask -> DONE.
//     Write miss: no line change, no allocate.
//   - DONE: resp_b=1 for exactly one cycle; rdata_b = selected word for loads, 0 for stores -> IDLE.
// - Requester changes the request only after resp_b, so DONE never re-serves a request. IDLE services whatever is present the next cycle.
// - No new request is accepted outside IDLE; inputs are sampled live and must stay stable.
// - Reset mid-FILL/WRITE: abort. pmem_* deassert the next cycle; the partially filled line stays invalid.
// - pmem_resp in IDLE/DONE: ignored.
// CONFIGURATION
// - DCACHE_PERF_EN defined: adds outputs hit_count[31:0] and miss_count[31:0].
//   - IDLE read hit: hit_count++. Entering FILL: miss_count++. Writes are not counted.
//   - Both counters wrap at 2^32 and reset to 0.
// - DCACHE_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
// - rv32i_types: dcache_state_t enum {IDLE,FILL,WRITE,DONE}; dcache_line_t (4 x rv32i_word);
//   localparams DCACHE_OFFSET_BITS=4, DCACHE_BEATS=4.
// - Sub-module dcache_array: valid/tag/data flop arrays. Async read; sync write with per-word byte enables; valid clear on rst_n.
// - Top holds the FSM, beat counter, address split and output muxing.
// TESTING
// - Cold read 0x40 -> FILL, pmem_address=0x40; beats 0x11,0x22,0x33,0x44 -> DONE resp_b, rdata_b=0x11. Read 0x44 -> same-cycle resp_b, 0x22.
// - After test 1, store 0x48 wdata=0xAAAABBBB wmask=0011 -> pmem_write addr 0x48 mask 0011; pmem_resp -> resp_b next cycle.
//   Then read 0x48 hits, returns 0x0000BBBB.
// - Store miss 0x100 -> one pmem_write, no pmem_read. Next read 0x100 -> FILL (no allocate).
// - Conflict: fill 0x40, then read 0x140 (same index) -> FILL evicts. Read 0x40 -> FILL again.
// - rst_n low during beat 2 of a fill -> pmem_read 0 next cycle, resp_b never pulses. Re-read of the same address misses.
// - DCACHE_PERF_EN: sequence of tests 1+4 -> hit_count=1, miss_count=3. Reset clears both to 0.

Source files
------------

// File: rtl/dcache_port_b_pkg.sv
// Shared types and constants for the port-B data cache.
//   dcache_state_t : controller states IDLE/FILL/WRITE/DONE
//   dcache_line_t  : one 16-byte line as DCACHE_BEATS packed 32-bit words
//   merge_word()   : byte-lane merge of store data into an existing word
package dcache_port_b_pkg;

  localparam int unsigned DCACHE_OFFSET_BITS = 4;
  localparam int unsigned DCACHE_BEATS       = 4;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } dcache_state_t;

  typedef logic [DCACHE_BEATS-1:0][31:0] dcache_line_t;

  function automatic rv32i_word merge_word(input rv32i_word old_w,
                                           input rv32i_word new_w,
                                           input logic [3:0] mask);
    rv32i_word r;
    r = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_port_b_if.sv
// MEM-stage port-B handshake bundle.
//   master : the MEM stage (drives read_b/write/wmask/address_b/wdata)
//   slave  : the cache (drives resp_b/rdata_b)
interface dcache_port_b_if;
  logic        read_b;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] address_b;
  logic [31:0] wdata;
  logic        resp_b;
  logic [31:0] rdata_b;

  modport master (output read_b, write, wmask, address_b, wdata,
                  input  resp_b, rdata_b);
  modport slave  (input  read_b, write, wmask, address_b, wdata,
                  output resp_b, rdata_b);
endinterface

// File: rtl/dcache_port_b_array.sv
// Valid/tag/data storage for the direct-mapped cache.
//   clk, rst_n    : clock; active-low synchronous reset clears valid bits only
//   idx_i         : set index shared by reads and writes
//   valid_o/tag_o/line_o : asynchronous read of the indexed set
//   data_we_i, word_i, be_i, data_i : byte-enabled write of one word
//   tag_we_i, tag_i : write tag and mark the set valid
module dcache_port_b_array
  import dcache_port_b_pkg::*;
#(
  parameter int unsigned SETS = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [$clog2(SETS)-1:0]                     idx_i,
  output logic                                        valid_o,
  output logic [31-DCACHE_OFFSET_BITS-$clog2(SETS):0] tag_o,
  output dcache_line_t                                line_o,
  input  logic                                        data_we_i,
  input  logic [1:0]                                  word_i,
  input  logic [3:0]                                  be_i,
  input  logic [31:0]                                 data_i,
  input  logic                                        tag_we_i,
  input  logic [31-DCACHE_OFFSET_BITS-$clog2(SETS):0] tag_i
);

  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned TAGW = 32 - DCACHE_OFFSET_BITS - IDXW;

  logic [SETS-1:0] valid_q;
  logic [TAGW-1:0] tag_q  [SETS];
  dcache_line_t    data_q [SETS];

  assign valid_o = valid_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we_i) tag_q[idx_i] <= tag_i;
    if (data_we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) data_q[idx_i][word_i][8*b +: 8] <= data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_port_b.sv
// Blocking direct-mapped write-through, no-write-allocate data cache for
// the MEM stage's port B. 16-byte lines refilled by a 4-beat pmem burst.
//   clk, rst_n          : clock, synchronous active-low reset
//   mem (slave)         : read_b/write/wmask/address_b/wdata in, resp_b/rdata_b out
//   pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_wmask : pmem request
//   pmem_rdata/pmem_resp: pmem beat data and acknowledge
// Optional macro DCACHE_PERF_EN adds hit_count/miss_count outputs.
module dcache_port_b
  import dcache_port_b_pkg::*;
#(
  parameter int unsigned SETS  = 16,
  parameter int unsigned BEATS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  dcache_port_b_if.slave mem,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_wmask,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDXW   = $clog2(SETS);
  localparam int unsigned TAGW   = 32 - DCACHE_OFFSET_BITS - IDXW;
  localparam int unsigned BEAT_W = $clog2(DCACHE_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  dcache_state_t     state_q;
  logic [BEAT_W-1:0] beat_q;

  logic [TAGW-1:0] tag_in;
  logic [IDXW-1:0] idx_in;
  logic [1:0]      word_in;
  logic            unused_addr;

  assign tag_in      = mem.address_b[31 -: TAGW];
  assign idx_in      = mem.address_b[DCACHE_OFFSET_BITS +: IDXW];
  assign word_in     = mem.address_b[3:2];
  assign unused_addr = ^mem.address_b[1:0];

  logic            arr_valid;
  logic [TAGW-1:0] arr_tag;
  dcache_line_t    arr_line;
  logic            hit;
  logic            data_we;
  logic            tag_we;
  logic [1:0]      wr_word;
  logic [3:0]      wr_be;
  logic [31:0]     wr_data;

  assign hit = arr_valid && (arr_tag == tag_in);

  dcache_port_b_array #(.SETS(SETS)) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx_i     (idx_in),
    .valid_o   (arr_valid),
    .tag_o     (arr_tag),
    .line_o    (arr_line),
    .data_we_i (data_we),
    .word_i    (wr_word),
    .be_i      (wr_be),
    .data_i    (wr_data),
    .tag_we_i  (tag_we),
    .tag_i     (tag_in)
  );

  // Refill beats land in word[beat]; the tag/valid update rides on the last
  // beat so a fill aborted by reset never leaves a valid line behind.
  always_comb begin
    data_we = 1'b0;
    tag_we  = 1'b0;
    wr_word = word_in;
    wr_be   = '0;
    wr_data = mem.wdata;
    unique case (state_q)
      FILL: begin
        if (pmem_resp) begin
          data_we = 1'b1;
          wr_word = beat_q;
          wr_be   = '1;
          wr_data = pmem_rdata;
          tag_we  = (beat_q == LAST_BEAT);
        end
      end
      WRITE: begin
        if (pmem_resp && hit) begin
          data_we = 1'b1;
          wr_be   = mem.wmask;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem.resp_b   = 1'b0;
    mem.rdata_b  = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    pmem_wmask   = '0;
    unique case (state_q)
      IDLE: begin
        if (mem.read_b && !mem.write && hit) begin
          mem.resp_b  = 1'b1;
          mem.rdata_b = arr_line[word_in];
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mem.address_b[31:DCACHE_OFFSET_BITS], {DCACHE_OFFSET_BITS{1'b0}}};
      end
      WRITE: begin
        pmem_write   = 1'b1;
        pmem_address = {mem.address_b[31:2], 2'b00};
        pmem_wdata   = mem.wdata;
        pmem_wmask   = mem.wmask;
      end
      DONE: begin
        mem.resp_b  = 1'b1;
        mem.rdata_b = mem.write ? '0 : arr_line[word_in];
      end
      default: ;
    endcase
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
`ifdef DCACHE_PERF_EN
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem.write) begin
            state_q <= WRITE;
          end else if (mem.read_b) begin
            if (hit) begin
`ifdef DCACHE_PERF_EN
              hit_cnt_q <= hit_cnt_q + 32'd1;
`endif
            end else begin
              state_q <= FILL;
              beat_q  <= '0;
`ifdef DCACHE_PERF_EN
              miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
            end
          end
        end
        FILL: begin
          if (pmem_resp) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) state_q <= DONE;
          end
        end
        WRITE: begin
          if (pmem_resp) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_port_b.sv
// Scoreboard bench for dcache_port_b: a stimulus process computes each
// expected load/store response from a line-level cache model and pushes it
// into a queue; a monitor pops and compares whenever resp_b is seen. A pmem
// responder backs the cache with its own memory image and random delays.
// Build with +define+DCACHE_PERF_EN to also check hit_count/miss_count.
module tb_dcache_port_b;

  localparam int unsigned SETS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_port_b_if bus ();

  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address, pmem_wdata;
  logic [3:0]  pmem_wmask;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;
`ifdef DCACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_port_b #(.SETS(SETS), .BEATS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem          (bus),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_wmask   (pmem_wmask),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef DCACHE_PERF_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q[$];

  // Reference model: per-set valid/tag/words plus the requester's view of memory.
  bit          mv [SETS];
  logic [23:0] mt [SETS];
  logic [31:0] md [SETS][4];
  logic [31:0] rmem [logic [31:0]];
  logic [31:0] bmem [logic [31:0]];
  int unsigned m_hits = 0, m_miss = 0;

  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wmask;
  int unsigned tb_beat = 0, fill_cnt = 0, wr_cnt = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h3C5A_0000;
  endfunction

  function automatic logic [31:0] rmem_rd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL global_timeout actual=still running required=finished");
    finish_run();
  end

  // pmem responder: random-latency beats, write acks, and stray acks while idle.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = $urandom;
      if (!rst_n) begin
        tb_beat = 0;
      end else if (pmem_read) begin
        if ($urandom_range(0, 2) != 0) begin
          check("fill_addr", pmem_address, {cur_addr[31:4], 4'b0});
          pmem_rdata = bmem_rd({cur_addr[31:4], 4'b0} + (32'(tb_beat) << 2));
          pmem_resp  = 1'b1;
          tb_beat++;
          if (tb_beat == 4) begin
            tb_beat = 0;
            fill_cnt++;
          end
        end
      end else if (pmem_write) begin
        if ($urandom_range(0, 2) != 0) begin
          check("wr_addr", pmem_address, {cur_addr[31:2], 2'b0});
          check("wr_data", pmem_wdata, cur_wdata);
          check("wr_mask", 32'(pmem_wmask), 32'(cur_wmask));
          bmem[{cur_addr[31:2], 2'b0}] = merge(bmem_rd({cur_addr[31:2], 2'b0}),
                                               pmem_wdata, pmem_wmask);
          pmem_resp = 1'b1;
          wr_cnt++;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        pmem_resp = 1'b1;
      end
    end
  end

  // Monitor: every resp_b must match the oldest expected response.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.resp_b) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=resp_b=1 required=no pending request t=%0t", $time);
          end else begin
            check("rdata_b", bus.rdata_b, exp_q.pop_front());
          end
        end else begin
          check("rdata_idle", bus.rdata_b, 32'h0);
        end
      end
    end
  end

  task automatic do_req(input bit st, input bit both, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] wm);
    int unsigned idx, w, f0, w0, n;
    logic [23:0] tg;
    logic [31:0] line_a;
    bit hit, seen;
    idx    = int'(a[7:4]);
    w      = int'(a[3:2]);
    tg     = a[31:8];
    line_a = {a[31:4], 4'b0};
    hit    = mv[idx] && (mt[idx] == tg);
    f0     = fill_cnt;
    w0     = wr_cnt;
    seen   = 1'b0;
    if (st) begin
      rmem[{a[31:2], 2'b0}] = merge(rmem_rd({a[31:2], 2'b0}), wd, wm);
      if (hit) md[idx][w] = merge(md[idx][w], wd, wm);
      exp_q.push_back(32'h0);
    end else if (hit) begin
      m_hits++;
      exp_q.push_back(md[idx][w]);
    end else begin
      m_miss++;
      for (int k = 0; k < 4; k++) md[idx][k] = rmem_rd(line_a + 32'(4 * k));
      mv[idx] = 1'b1;
      mt[idx] = tg;
      exp_q.push_back(md[idx][w]);
    end
    cur_addr      = a;
    cur_wdata     = wd;
    cur_wmask     = wm;
    bus.address_b = a;
    bus.wdata     = wd;
    bus.wmask     = wm;
    bus.write     = st;
    bus.read_b    = !st || both;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.resp_b) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout addr=%h actual=no resp_b required=resp_b within 200 cycles", a);
      finish_run();
    end
    check("zero_latency_hit", 32'(n == 0), 32'(!st && hit));
    check("fill_bursts", fill_cnt - f0, (!st && !hit) ? 32'd1 : 32'd0);
    check("pmem_writes", wr_cnt - w0, st ? 32'd1 : 32'd0);
    @(posedge clk);
    #1;
    bus.read_b = 1'b0;
    bus.write  = 1'b0;
  endtask

  initial begin
    int unsigned n;
    logic [31:0] a;
    bus.read_b    = 1'b0;
    bus.write     = 1'b0;
    bus.wmask     = '0;
    bus.address_b = '0;
    bus.wdata     = '0;
    cur_addr      = '0;
    cur_wdata     = '0;
    cur_wmask     = '0;
    for (int s = 0; s < int'(SETS); s++) mv[s] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bmem[32'h40 + 32'(4 * k)] = 32'h11 * 32'(k + 1);
      rmem[32'h40 + 32'(4 * k)] = 32'h11 * 32'(k + 1);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_b", 32'(bus.resp_b), 32'h0);
    check("rst_rdata_b", bus.rdata_b, 32'h0);
    check("rst_pmem_read", 32'(pmem_read), 32'h0);
    check("rst_pmem_write", 32'(pmem_write), 32'h0);
    check("rst_pmem_address", pmem_address, 32'h0);
`ifdef DCACHE_PERF_EN
    check("rst_hit_count", hit_count, 32'h0);
    check("rst_miss_count", miss_count, 32'h0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    do_req(1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
    do_req(1'b0, 1'b0, 32'h44, 32'h0, 4'h0);
    do_req(1'b1, 1'b0, 32'h48, 32'hAAAA_BBBB, 4'b0011);
    do_req(1'b0, 1'b0, 32'h48, 32'h0, 4'h0);
    check("merged_word_model", md[4][2], 32'h0000_BBBB);
    do_req(1'b1, 1'b0, 32'h100, 32'h1234_5678, 4'hF);
    do_req(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
    do_req(1'b0, 1'b0, 32'h140, 32'h0, 4'h0);
    do_req(1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
    do_req(1'b1, 1'b1, 32'h44, 32'hDEAD_BEEF, 4'b1100);
`ifdef DCACHE_PERF_EN
    check("hit_count_directed", hit_count, 32'(m_hits));
    check("miss_count_directed", miss_count, 32'(m_miss));
`endif

    // Reset in the middle of a refill.
    cur_addr      = 32'h2C4;
    bus.address_b = 32'h2C4;
    bus.read_b    = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(posedge clk);
      if (tb_beat == 2) break;
    end
    check("reached_beat2", 32'(tb_beat), 32'd2);
    #1;
    rst_n      = 1'b0;
    bus.read_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_pmem_read", 32'(pmem_read), 32'h0);
    check("abort_resp_b", 32'(bus.resp_b), 32'h0);
`ifdef DCACHE_PERF_EN
    check("abort_hit_count", hit_count, 32'h0);
    check("abort_miss_count", miss_count, 32'h0);
`endif
    for (int s = 0; s < int'(SETS); s++) mv[s] = 1'b0;
    m_hits = 0;
    m_miss = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_req(1'b0, 1'b0, 32'h2C4, 32'h0, 4'h0);

    for (int i = 0; i < 300; i++) begin
      bit st;
      st = ($urandom_range(0, 2) == 0);
      a  = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4) |
           32'($urandom_range(0, 15));
      do_req(st, st && ($urandom_range(0, 1) == 1), a, $urandom, 4'($urandom_range(0, 15)));
    end

`ifdef DCACHE_PERF_EN
    check("hit_count_final", hit_count, 32'(m_hits));
    check("miss_count_final", miss_count, 32'(m_miss));
`endif
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    finish_run();
  end

endmodule
